// File: rtl/pirs_inverse_pkg.sv
// Shared definitions for the PIRS inverse scanner: controller states,
// default on-set of the scanned function and width of the match counter.
package pirs_inverse_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      EMIT = 2'd2,
      DONE = 2'd3
   } state_e;

   // Bit i of the on-set means f(i)=1; the default marks codes {0,2,6,7,9,11}.
   localparam logic [15:0] DEFAULT_ONSET = 16'h0AC5;
   localparam int          COUNT_W       = 5;

endpackage

// File: rtl/pirs_inverse_func.sv
// Purely combinational evaluator of the scanned 4-input boolean function,
// looked up directly from its on-set mask.
module pirs_func
   import pirs_inverse_pkg::*;
#(
   parameter logic [15:0] ONSET = DEFAULT_ONSET
) (
   input  logic [3:0] code_i,
   output logic       f_o
);

   assign f_o = ONSET[code_i];

endmodule

// File: rtl/pirs_inverse.sv
// Inverse-image scanner: walks codes 0..15 once per request and hands every
// code whose function value equals the captured target to a ready/valid consumer.
module pirs_inverse
   import pirs_inverse_pkg::*;
#(
   parameter logic [15:0] ONSET = DEFAULT_ONSET
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               target,
   input  logic               abort,
   input  logic               out_ready,
   output logic               busy,
   output logic               x_valid,
   output logic [3:0]         x_out,
   output logic               done,
   output logic [COUNT_W-1:0] count
);

   state_e             state_q, state_d;
   logic [3:0]         idx_q, idx_d;
   logic               tgt_q, tgt_d;
   logic [3:0]         xOut_q, xOut_d;
   logic               xValid_q, xValid_d;
   logic [COUNT_W-1:0] count_q, count_d;
   logic               fIdx;

   pirs_func #(
      .ONSET (ONSET)
   ) uFunc (
      .code_i (idx_q),
      .f_o    (fIdx)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      tgt_d    = tgt_q;
      xOut_d   = xOut_q;
      xValid_d = xValid_q;
      count_d  = count_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               tgt_d   = target;
               idx_d   = 4'd0;
               count_d = '0;
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (abort) begin
               xValid_d = 1'b0;
               state_d  = IDLE;
            end else if (fIdx == tgt_q) begin
               xOut_d   = idx_q;
               xValid_d = 1'b1;
               state_d  = EMIT;
            end else if (idx_q == 4'd15) begin
               state_d = DONE;
            end else begin
               idx_d = idx_q + 4'd1;
            end
         end
         EMIT: begin
            // Abort wins over a simultaneous handshake, so that transfer is dropped.
            if (abort) begin
               xValid_d = 1'b0;
               state_d  = IDLE;
            end else if (xValid_q && out_ready) begin
               xValid_d = 1'b0;
               count_d  = count_q + 1'b1;
               if (idx_q == 4'd15) begin
                  state_d = DONE;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  state_d = SCAN;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         idx_q    <= 4'd0;
         tgt_q    <= 1'b0;
         xOut_q   <= 4'd0;
         xValid_q <= 1'b0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         tgt_q    <= tgt_d;
         xOut_q   <= xOut_d;
         xValid_q <= xValid_d;
         count_q  <= count_d;
      end
   end

   assign busy    = (state_q == SCAN) || (state_q == EMIT);
   assign done    = (state_q == DONE);
   assign x_valid = xValid_q;
   assign x_out   = xOut_q;
   assign count   = count_q;

endmodule

// File: tb/tb_pirs_inverse.sv
// Directed bench for pirs_inverse: full scans for both targets, stalls,
// abort, mid-scan reset and start/target disturbance during a scan.
module tb_pirs_inverse;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       target;
   logic       abort;
   logic       out_ready;
   logic       busy;
   logic       x_valid;
   logic [3:0] x_out;
   logic       done;
   logic [4:0] count;

   int nAsserts = 0;
   int nFail    = 0;
   int seq[$];
   int busyCnt;
   int doneCnt;

   // Hand-derived inverse images of the default on-set 16'h0AC5.
   int onList[6]   = '{0, 2, 6, 7, 9, 11};
   int offList[10] = '{1, 3, 4, 5, 8, 10, 12, 13, 14, 15};

   pirs_inverse dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .target    (target),
      .abort     (abort),
      .out_ready (out_ready),
      .busy      (busy),
      .x_valid   (x_valid),
      .x_out     (x_out),
      .done      (done),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAsserts++;
      assert (obs === exp)
      else begin
         nFail++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Runs one scan from the current negedge; stall = cycles out_ready is held low per match.
   task automatic applyStimulus(input logic tgtVal, input int stall, input bit disturb);
      int         stallLeft;
      logic [3:0] held;
      logic       prevValid;
      bit         finished;
      seq.delete();
      busyCnt   = 0;
      doneCnt   = 0;
      prevValid = 1'b0;
      finished  = 1'b0;
      stallLeft = 0;
      held      = 4'd0;
      start     = 1'b1;
      target    = tgtVal;
      out_ready = (stall == 0);
      for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
         @(negedge clk);
         start = disturb ? cyc[0] : 1'b0;
         if (disturb) target = ~target;
         if (busy) busyCnt++;
         if (done) begin
            doneCnt++;
            finished = 1'b1;
         end
         if (x_valid) begin
            if (!prevValid) begin
               stallLeft = stall;
               held      = x_out;
            end else begin
               checkOutput("stall_hold_xout", x_out, held);
            end
            if (stallLeft > 0) begin
               out_ready = 1'b0;
               stallLeft--;
            end else begin
               out_ready = 1'b1;
               seq.push_back(int'(x_out));
            end
         end
         prevValid = x_valid;
      end
      start = 1'b0;
      if (!finished) checkOutput("scan_timeout", 32'd0, 32'd1);
   endtask

   task automatic checkSeq(input logic tgtVal);
      if (tgtVal) begin
         checkOutput("seq_len_on", seq.size(), 6);
         for (int i = 0; i < 6 && i < seq.size(); i++) checkOutput("seq_on", seq[i], onList[i]);
      end else begin
         checkOutput("seq_len_off", seq.size(), 10);
         for (int i = 0; i < 10 && i < seq.size(); i++) checkOutput("seq_off", seq[i], offList[i]);
      end
   endtask

   initial begin
      bit found;
      rst_n     = 1'b0;
      start     = 1'b0;
      target    = 1'b0;
      abort     = 1'b0;
      out_ready = 1'b0;
      #12;
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_valid", x_valid, 0);
      checkOutput("rst_xout", x_out, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_count", count, 0);

      $display("[TB] scan target=1, no stall");
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1'b1, 0, 1'b0);
      checkSeq(1'b1);
      checkOutput("t1_count", count, 6);
      checkOutput("t1_busy_cycles", busyCnt, 22);
      checkOutput("t1_done_pulses", doneCnt, 1);
      @(negedge clk);
      checkOutput("t1_done_one_cycle", done, 0);
      checkOutput("t1_idle_busy", busy, 0);
      checkOutput("t1_count_hold", count, 6);

      $display("[TB] scan target=0, no stall");
      applyStimulus(1'b0, 0, 1'b0);
      checkSeq(1'b0);
      checkOutput("t2_count", count, 10);
      checkOutput("t2_busy_cycles", busyCnt, 26);
      checkOutput("t2_done_pulses", doneCnt, 1);

      $display("[TB] scan target=1, 3-cycle stall per match");
      @(negedge clk);
      applyStimulus(1'b1, 3, 1'b0);
      checkSeq(1'b1);
      checkOutput("t3_count", count, 6);
      checkOutput("t3_done_pulses", doneCnt, 1);

      $display("[TB] abort while code 6 is waiting");
      @(negedge clk);
      start     = 1'b1;
      target    = 1'b1;
      out_ready = 1'b1;
      found     = 1'b0;
      for (int cyc = 0; cyc < 60 && !found; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         if (x_valid && x_out == 4'd6) found = 1'b1;
      end
      checkOutput("t4_reach_code6", found, 1);
      abort     = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checkOutput("t4_valid_drop", x_valid, 0);
      checkOutput("t4_busy_drop", busy, 0);
      checkOutput("t4_count", count, 2);
      checkOutput("t4_no_done", done, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("t4_no_done_later", done, 0);
         checkOutput("t4_count_hold", count, 2);
      end

      $display("[TB] reset mid-scan at code 9");
      start     = 1'b1;
      target    = 1'b1;
      out_ready = 1'b1;
      found     = 1'b0;
      for (int cyc = 0; cyc < 60 && !found; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         if (x_valid && x_out == 4'd9) found = 1'b1;
      end
      checkOutput("t5_reach_code9", found, 1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("t5_rst_busy", busy, 0);
      checkOutput("t5_rst_valid", x_valid, 0);
      checkOutput("t5_rst_xout", x_out, 0);
      checkOutput("t5_rst_done", done, 0);
      checkOutput("t5_rst_count", count, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("t5_no_done", done, 0);
         checkOutput("t5_idle", busy, 0);
      end
      applyStimulus(1'b1, 0, 1'b0);
      checkSeq(1'b1);
      checkOutput("t5_count", count, 6);

      $display("[TB] start re-pulsed and target toggled during scan");
      @(negedge clk);
      applyStimulus(1'b0, 0, 1'b1);
      checkSeq(1'b0);
      checkOutput("t6_count", count, 10);
      checkOutput("t6_busy_cycles", busyCnt, 26);
      checkOutput("t6_done_pulses", doneCnt, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
      $finish;
   end

endmodule

// File: doc/pirs_inverse.md
PIRS_INVERSE -- requirements
Module: pirs_inverse

Interface
REQ-001 Parameter ONSET, default 16'h0AC5; bit i set means f(i)=1 (on-set {0,2,6,7,9,11}).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a scan; sampled in IDLE only.
REQ-005 target  input  1  wanted f value; captured when start is accepted.
REQ-006 abort  input  1  cancel an active scan.
REQ-007 out_ready  input  1  consumer accepts x_out.
REQ-008 busy  output  1  high in SCAN and EMIT.
REQ-009 x_valid  output  1  x_out holds a matching input code.
REQ-010 x_out  output  4  matching input code.
REQ-011 done  output  1  one-cycle pulse at scan completion.
REQ-012 count  output  5  matches transferred in the current or last scan, 0..16.

Function
REQ-013 States: IDLE, SCAN, EMIT, DONE; 4-bit index idx; registered target copy tgt.
REQ-014 IDLE with start=1: tgt<=target, idx<=0, count<=0, next state SCAN; start is ignored in all other states.
REQ-015 SCAN evaluates f(idx) once per cycle; match means f(idx)==tgt.
REQ-016 SCAN on match: x_out<=idx, x_valid<=1, next state EMIT.
REQ-017 SCAN on no match: idx<15 gives idx+1 and stays in SCAN; idx==15 gives DONE.
REQ-018 EMIT: a transfer occurs when x_valid&out_ready; on transfer x_valid<=0 and count<=count+1.
REQ-019 EMIT after a transfer: idx<15 gives idx+1 and SCAN; idx==15 gives DONE.
REQ-020 EMIT without a transfer holds x_out and x_valid stable.
REQ-021 DONE: done=1 for exactly one cycle, then IDLE; count holds until the next accepted start.
REQ-022 Codes are emitted in ascending order, each at most once; idx never wraps within a scan.
REQ-023 With out_ready held high, busy lasts exactly 16+N cycles (N = number of matches), and done follows in the next cycle.
REQ-024 abort in SCAN or EMIT: next state IDLE, x_valid<=0, no done pulse, count keeps the value at abort time.
REQ-025 abort takes priority over a transfer in the same cycle; that transfer is not counted.
REQ-026 Changes on target during a scan have no effect.

Reset
REQ-027 rst_n low asynchronously forces: state IDLE, idx 0, tgt 0, x_out 0, x_valid 0, done 0, busy 0, count 0.
REQ-028 Reset asserted mid-scan discards all progress; no done pulse follows deassertion.
REQ-029 The first start is accepted on the first rising edge after rst_n deasserts.

Structure
REQ-030 Shared package holds the state enum, the default ONSET constant 16'h0AC5, and the count width 5.
REQ-031 One combinational sub-module, pirs_func (4-bit in, 1-bit f = ONSET[in]), is instantiated for evaluation.
REQ-032 Single always block for state and registers, with combinational next-state logic; no latches.

Verification
REQ-033 Start with target=1 and out_ready=1: x_out sequence 0,2,6,7,9,11; count=6; busy 22 cycles; one done pulse.
REQ-034 Start with target=0 and out_ready=1: x_out sequence 1,3,4,5,8,10,12,13,14,15; count=10; busy 26 cycles.
REQ-035 target=1 with out_ready low for 3 cycles at each match: x_out/x_valid stable while stalled; same sequence; count=6.
REQ-036 abort while x_out=6 is waiting: x_valid drops next cycle; IDLE; no done; count=2.
REQ-037 rst_n pulsed low mid-scan at idx=9: all outputs reset immediately; a new start rescans from 0.
REQ-038 start re-pulsed and target toggled during a scan: no effect; results match the target captured at start.
